leitor_caminho: RTL and testbench

Host-side requester and path reader for the pathfinding accelerator. It accepts a (source, destination) command and pulses start into the top-level controller. It then waits for path-ready, walks the predecessor memory backward from destination to source, and streams each node to the host over a valid/accept interface. It pulses read-done so the controller returns to idle.

---
 rtl/leitor_caminho_pkg.sv | 19 +
 rtl/leitor_caminho.sv | 155 +++++++++++++++
 tb/tb_leitor_caminho.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/leitor_caminho_pkg.sv
// Shared definitions for the path reader: FSM state encodings and the
// "no predecessor" marker also used by the predecessor-memory writer.
package leitor_caminho_pkg;

  localparam int LC_ADDR_WIDTH = 6;

  localparam logic [LC_ADDR_WIDTH-1:0] NO_INVALIDO = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INICIAR  = 3'd1,
    ST_AGUARDAR = 3'd2,
    ST_EMITIR   = 3'd3,
    ST_LER      = 3'd4,
    ST_ESPERAR  = 3'd5,
    ST_LIDO     = 3'd6
  } estado_t;

endpackage

// File: rtl/leitor_caminho.sv
// Host-side requester and path reader: issues start to the controller, then
// walks the predecessor memory from destination back to source, streaming nodes.
module leitor_caminho
  import leitor_caminho_pkg::*;
#(
  parameter int ADDR_WIDTH = LC_ADDR_WIDTH,
  parameter int MAX_PASSOS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  comando_valido_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  comando_pronto_out,
  output logic                  saida_valida_out,
  output logic [ADDR_WIDTH-1:0] saida_no_out,
  output logic                  saida_ultimo_out,
  input  logic                  saida_aceita_in,
  output logic                  erro_out,
  input  logic                  aguardando_in,
  input  logic                  caminho_pronto_in,
  output logic                  iniciar_out,
  output logic                  lido_out,
  output logic [ADDR_WIDTH-1:0] fonte_out,
  output logic [ADDR_WIDTH-1:0] destino_out,
  output logic                  mem_leitura_out,
  output logic [ADDR_WIDTH-1:0] mem_endereco_out,
  input  logic [ADDR_WIDTH-1:0] mem_dado_in
);

  localparam int PW = $clog2(MAX_PASSOS + 1);

  estado_t               estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] no_atual_q, no_atual_d;
  logic [ADDR_WIDTH-1:0] fonte_q, fonte_d;
  logic [ADDR_WIDTH-1:0] destino_q, destino_d;
  logic [PW-1:0]         passos_q, passos_d;
  logic                  erro_q, erro_d;

  logic                  aceito;
  logic                  ultimo;
  logic                  sem_pred;
  logic [PW-1:0]         passos_inc;
  logic                  limite;

  assign aceito     = (estado_q == ST_IDLE) && comando_valido_in && aguardando_in;
  assign ultimo     = (no_atual_q == fonte_q);
  assign sem_pred   = (mem_dado_in == NO_INVALIDO);
  assign passos_inc = passos_q + PW'(1);
  assign limite     = (passos_inc == PW'(MAX_PASSOS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q   <= ST_IDLE;
      no_atual_q <= '0;
      fonte_q    <= '0;
      destino_q  <= '0;
      passos_q   <= '0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      no_atual_q <= no_atual_d;
      fonte_q    <= fonte_d;
      destino_q  <= destino_d;
      passos_q   <= passos_d;
      erro_q     <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE:     if (aceito) estado_d = ST_INICIAR;
      ST_INICIAR:  estado_d = ST_AGUARDAR;
      ST_AGUARDAR: if (caminho_pronto_in) estado_d = ST_EMITIR;
      ST_EMITIR: begin
        if (saida_aceita_in) begin
          if (ultimo || limite) estado_d = ST_LIDO;
          else                  estado_d = ST_LER;
        end
      end
      ST_LER:      estado_d = ST_ESPERAR;
      ST_ESPERAR:  estado_d = sem_pred ? ST_LIDO : ST_EMITIR;
      ST_LIDO:     estado_d = ST_IDLE;
      default:     estado_d = ST_IDLE;
    endcase
  end

  // The guard only trips on a beat that is not the source, so a path of exactly
  // MAX_PASSOS nodes still completes cleanly.
  always_comb begin
    no_atual_d = no_atual_q;
    fonte_d    = fonte_q;
    destino_d  = destino_q;
    passos_d   = passos_q;
    erro_d     = erro_q;
    case (estado_q)
      ST_IDLE: begin
        if (aceito) begin
          fonte_d   = fonte_in;
          destino_d = destino_in;
          erro_d    = 1'b0;
        end
      end
      ST_AGUARDAR: begin
        if (caminho_pronto_in) begin
          no_atual_d = destino_q;
          passos_d   = '0;
        end
      end
      ST_EMITIR: begin
        if (saida_aceita_in) begin
          passos_d = passos_inc;
          if (!ultimo && limite) erro_d = 1'b1;
        end
      end
      ST_ESPERAR: begin
        if (sem_pred) erro_d = 1'b1;
        else          no_atual_d = mem_dado_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    comando_pronto_out = 1'b0;
    saida_valida_out   = 1'b0;
    saida_no_out       = '0;
    saida_ultimo_out   = 1'b0;
    iniciar_out        = 1'b0;
    lido_out           = 1'b0;
    mem_leitura_out    = 1'b0;
    mem_endereco_out   = '0;
    case (estado_q)
      ST_IDLE:    comando_pronto_out = aguardando_in;
      ST_INICIAR: iniciar_out = 1'b1;
      ST_EMITIR: begin
        saida_valida_out = 1'b1;
        saida_no_out     = no_atual_q;
        saida_ultimo_out = ultimo;
      end
      ST_LER: begin
        mem_leitura_out  = 1'b1;
        mem_endereco_out = no_atual_q;
      end
      ST_LIDO:    lido_out = 1'b1;
      default: ;
    endcase
  end

  assign erro_out    = erro_q;
  assign fonte_out   = fonte_q;
  assign destino_out = destino_q;

endmodule

// File: tb/tb_leitor_caminho.sv
// Directed bench for leitor_caminho: drives commands and host acceptance,
// models the predecessor memory, and checks beats, reads and pulses.
module tb_leitor_caminho;
  import leitor_caminho_pkg::*;

  localparam int AW = 6;
  localparam int MP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          comando_valido_in;
  logic [AW-1:0] fonte_in, destino_in;
  logic          comando_pronto_out;
  logic          saida_valida_out;
  logic [AW-1:0] saida_no_out;
  logic          saida_ultimo_out;
  logic          saida_aceita_in;
  logic          erro_out;
  logic          aguardando_in;
  logic          caminho_pronto_in;
  logic          iniciar_out;
  logic          lido_out;
  logic [AW-1:0] fonte_out, destino_out;
  logic          mem_leitura_out;
  logic [AW-1:0] mem_endereco_out;
  logic [AW-1:0] mem_dado_in = '0;

  int vector_count = 0;
  int miss_count   = 0;
  int cyc          = 0;
  int lido_cnt     = 0;
  int iniciar_cnt  = 0;
  int beat_no[$], beat_ult[$], beat_cyc[$], reads[$];
  logic [AW-1:0] pred [64];

  leitor_caminho #(.ADDR_WIDTH(AW), .MAX_PASSOS(MP)) dut (
    .clk                (clk),
    .rst                (rst),
    .comando_valido_in  (comando_valido_in),
    .fonte_in           (fonte_in),
    .destino_in         (destino_in),
    .comando_pronto_out (comando_pronto_out),
    .saida_valida_out   (saida_valida_out),
    .saida_no_out       (saida_no_out),
    .saida_ultimo_out   (saida_ultimo_out),
    .saida_aceita_in    (saida_aceita_in),
    .erro_out           (erro_out),
    .aguardando_in      (aguardando_in),
    .caminho_pronto_in  (caminho_pronto_in),
    .iniciar_out        (iniciar_out),
    .lido_out           (lido_out),
    .fonte_out          (fonte_out),
    .destino_out        (destino_out),
    .mem_leitura_out    (mem_leitura_out),
    .mem_endereco_out   (mem_endereco_out),
    .mem_dado_in        (mem_dado_in)
  );

  always #5 clk = ~clk;

  // Predecessor memory: one-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_leitura_out) mem_dado_in <= pred[mem_endereco_out];
  end

  always @(negedge clk) begin
    if (mem_leitura_out) reads.push_back(int'(mem_endereco_out));
    if (lido_out)        lido_cnt++;
    if (iniciar_out)     iniciar_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vector_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command and acts as host until lido_out; optionally
  // stalls acceptance of beat hold_no for hold_ciclos cycles.
  task automatic applyStimulus(input logic [AW-1:0] f, input logic [AW-1:0] d,
                               input int hold_no, input int hold_ciclos, input int espera);
    bit fim;
    bit segurado;
    int budget;
    beat_no.delete(); beat_ult.delete(); beat_cyc.delete(); reads.delete();
    lido_cnt = 0;
    iniciar_cnt = 0;
    @(negedge clk);
    aguardando_in = 1'b1;
    comando_valido_in = 1'b1;
    fonte_in = f;
    destino_in = d;
    #1;
    checkOutput("pronto_idle", comando_pronto_out, 1);
    @(negedge clk);
    comando_valido_in = 1'b0;
    aguardando_in = 1'b0;
    checkOutput("iniciar_pulso", iniciar_out, 1);
    checkOutput("erro_limpo", erro_out, 0);
    checkOutput("fonte_out", fonte_out, f);
    checkOutput("destino_out", destino_out, d);
    @(negedge clk);
    checkOutput("iniciar_fim", iniciar_out, 0);
    repeat (espera) @(negedge clk);
    checkOutput("valida_antes", saida_valida_out, 0);
    caminho_pronto_in = 1'b1;
    fim = 1'b0;
    segurado = 1'b0;
    budget = 0;
    while (!fim && budget < 200) begin
      @(negedge clk);
      budget++;
      if (lido_out) fim = 1'b1;
      else if (saida_valida_out) begin
        beat_no.push_back(int'(saida_no_out));
        beat_ult.push_back(int'(saida_ultimo_out));
        beat_cyc.push_back(cyc);
        if (!segurado && int'(saida_no_out) == hold_no) begin
          segurado = 1'b1;
          for (int k = 0; k < hold_ciclos; k++) begin
            @(negedge clk);
            checkOutput("hold_no", saida_no_out, hold_no);
            checkOutput("hold_valida", saida_valida_out, 1);
            checkOutput("hold_leitura", mem_leitura_out, 0);
          end
        end
        saida_aceita_in = 1'b1;
        @(negedge clk);
        saida_aceita_in = 1'b0;
        if (lido_out) fim = 1'b1;
      end
    end
    caminho_pronto_in = 1'b0;
    aguardando_in = 1'b1;
    if (!fim) checkOutput("timeout_lido", 0, 1);
    @(negedge clk);
    checkOutput("lido_pulsos", lido_cnt, 1);
    checkOutput("lido_fim", lido_out, 0);
    checkOutput("volta_idle", comando_pronto_out, 1);
  endtask

  task automatic verifyPath(input string tag, input int e_no[$], input int e_ult[$],
                            input int e_rd[$], input int e_erro, input bit ver_gap);
    int g;
    checkOutput({tag, "_nbeats"}, beat_no.size(), e_no.size());
    for (int i = 0; i < e_no.size(); i++) begin
      g = (i < beat_no.size()) ? beat_no[i] : -1;
      checkOutput({tag, "_no"}, g, e_no[i]);
      g = (i < beat_ult.size()) ? beat_ult[i] : -1;
      checkOutput({tag, "_ultimo"}, g, e_ult[i]);
      if (ver_gap && i > 0 && i < beat_cyc.size())
        checkOutput({tag, "_intervalo"}, beat_cyc[i] - beat_cyc[i-1], 3);
    end
    checkOutput({tag, "_nleituras"}, reads.size(), e_rd.size());
    for (int i = 0; i < e_rd.size(); i++) begin
      g = (i < reads.size()) ? reads[i] : -1;
      checkOutput({tag, "_endereco"}, g, e_rd[i]);
    end
    checkOutput({tag, "_erro"}, erro_out, e_erro);
  endtask

  initial begin
    int ini_antes;
    rst = 1'b1;
    comando_valido_in = 1'b0;
    fonte_in = '0;
    destino_in = '0;
    saida_aceita_in = 1'b0;
    aguardando_in = 1'b0;
    caminho_pronto_in = 1'b0;
    for (int i = 0; i < 64; i++) pred[i] = '1;
    #12;
    checkOutput("rst_valida", saida_valida_out, 0);
    checkOutput("rst_iniciar", iniciar_out, 0);
    checkOutput("rst_lido", lido_out, 0);
    checkOutput("rst_erro", erro_out, 0);
    checkOutput("rst_fonte", fonte_out, 0);
    checkOutput("rst_destino", destino_out, 0);
    checkOutput("rst_leitura", mem_leitura_out, 0);
    checkOutput("rst_pronto", comando_pronto_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Controller busy: the command must be held, not taken.
    comando_valido_in = 1'b1;
    fonte_in = 6'd3;
    destino_in = 6'd3;
    repeat (3) @(negedge clk);
    checkOutput("ocupado_pronto", comando_pronto_out, 0);
    checkOutput("ocupado_iniciar", iniciar_cnt, 0);

    applyStimulus(6'd3, 6'd3, -1, 0, 10);
    verifyPath("mesmo_no", '{3}, '{1}, '{}, 0, 1'b0);

    pred[9] = 6'd5; pred[5] = 6'd2; pred[2] = 6'd0;
    applyStimulus(6'd0, 6'd9, -1, 0, 3);
    verifyPath("cadeia", '{9, 5, 2, 0}, '{0, 0, 0, 1}, '{9, 5, 2}, 0, 1'b1);

    applyStimulus(6'd0, 6'd9, 5, 4, 2);
    verifyPath("contrapressao", '{9, 5, 2, 0}, '{0, 0, 0, 1}, '{9, 5, 2}, 0, 1'b0);

    pred[9] = '1;
    applyStimulus(6'd0, 6'd9, -1, 0, 2);
    verifyPath("inalcancavel", '{9}, '{0}, '{9}, 1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("erro_persiste", erro_out, 1);

    pred[1] = 6'd2; pred[2] = 6'd1;
    applyStimulus(6'd7, 6'd1, -1, 0, 2);
    verifyPath("laco", '{1, 2, 1, 2}, '{0, 0, 0, 0}, '{1, 2, 1}, 1, 1'b0);

    // Reset while waiting for the path.
    @(negedge clk);
    aguardando_in = 1'b1;
    comando_valido_in = 1'b1;
    fonte_in = 6'd4;
    destino_in = 6'd5;
    @(negedge clk);
    comando_valido_in = 1'b0;
    aguardando_in = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstm_fonte", fonte_out, 0);
    checkOutput("rstm_destino", destino_out, 0);
    checkOutput("rstm_erro", erro_out, 0);
    checkOutput("rstm_iniciar", iniciar_out, 0);
    checkOutput("rstm_valida", saida_valida_out, 0);
    checkOutput("rstm_pronto", comando_pronto_out, 0);
    @(negedge clk);
    rst = 1'b0;
    ini_antes = iniciar_cnt;
    lido_cnt = 0;
    caminho_pronto_in = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rstm_sem_iniciar", iniciar_cnt, ini_antes);
    checkOutput("rstm_sem_lido", lido_cnt, 0);
    checkOutput("pronto_ignorado", saida_valida_out, 0);
    caminho_pronto_in = 1'b0;
    aguardando_in = 1'b1;
    #1;
    checkOutput("pronto_segue_1", comando_pronto_out, 1);
    aguardando_in = 1'b0;
    #1;
    checkOutput("pronto_segue_0", comando_pronto_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
